// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges three writeback requesters and tracks pending long-latency rd.
// Latency: the grant is registered, so the regfile write appears 1 cycle after the valid/ready handshake.
// Backpressure: ready is per requester; pipe has priority, R1/R2 alternate round-robin, starvation forces R1/R2.
module regfile_wb_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  output logic        pipe_ready,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  input  logic        cp_valid,
  input  logic [4:0]  cp_rd,
  input  logic [31:0] cp_data,
  output logic        cp_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic [4:0]  chk_rd,
  output logic        hazard,
  output logic        regwrite,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic [31:0] busy_mask
);

  // One writeback beat: destination register plus the value to write.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  localparam logic [2:0] STARVE_LIMIT = 3'd4;

  logic [31:0] busy;
  logic [31:0] busy_next;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [2:0]  starve_cnt;
  logic        rr_ptr;      // 0: R1 (mc) wins a tie next, 1: R2 (cp) wins
  logic        starve;
  logic        pipe_gnt;
  logic        mc_gnt;
  logic        cp_gnt;
  logic        any_gnt;
  logic        iss_fire;
  wb_t         gnt_wb;
  wb_t         wb_q;

  // Arbitration: pipe first unless starvation is being relieved, then round-robin between mc and cp.
  // The override only holds pipe off while mc or cp is actually asking, so a requester that
  // withdraws cannot lock the pipeline out.
  always_comb begin
    starve     = (starve_cnt == STARVE_LIMIT) && (mc_valid || cp_valid);
    pipe_ready = reset && !starve;
    pipe_gnt   = pipe_valid && pipe_ready;
    mc_ready   = 1'b0;
    cp_ready   = 1'b0;
    if (reset && !pipe_gnt) begin
      if (mc_valid && cp_valid) begin
        mc_ready = !rr_ptr;
        cp_ready = rr_ptr;
      end else begin
        mc_ready = mc_valid;
        cp_ready = cp_valid;
      end
    end
    mc_gnt  = mc_valid && mc_ready;
    cp_gnt  = cp_valid && cp_ready;
    any_gnt = pipe_gnt || mc_gnt || cp_gnt;
  end

  // Select the payload of whichever requester won this cycle.
  always_comb begin
    gnt_wb = '0;
    if (pipe_gnt) begin
      gnt_wb.rd   = pipe_rd;
      gnt_wb.data = pipe_data;
    end else if (mc_gnt) begin
      gnt_wb.rd   = mc_rd;
      gnt_wb.data = mc_data;
    end else if (cp_gnt) begin
      gnt_wb.rd   = cp_rd;
      gnt_wb.data = cp_data;
    end
  end

  // Scoreboard update: long-latency writebacks retire their rd, accepted issues mark theirs.
  // A same-cycle retire and issue of one rd cannot both happen: the issue sees the old busy bit and stalls.
  always_comb begin
    iss_ready = reset && !busy[iss_rd];
    iss_fire  = iss_valid && iss_ready;
    clr_mask  = '0;
    set_mask  = '0;
    if (mc_gnt) clr_mask[mc_rd] = 1'b1;
    if (cp_gnt) clr_mask[cp_rd] = 1'b1;
    if (iss_fire) set_mask[iss_rd] = 1'b1;
    busy_next    = (busy & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  // Decode hazard query; x0 is never marked busy so it contributes nothing.
  always_comb begin
    hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];
  end

  // Scoreboard state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Starvation counter: counts cycles mc/cp wait, saturates at the limit, clears when either is served.
  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (mc_gnt || cp_gnt) begin
      starve_cnt <= '0;
    end else if ((mc_valid || cp_valid) && (starve_cnt != STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  // Round-robin pointer: after serving one of mc/cp, the other gets the next tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr <= 1'b0;
    end else if (mc_gnt) begin
      rr_ptr <= 1'b1;
    end else if (cp_gnt) begin
      rr_ptr <= 1'b0;
    end
  end

  // Registered regfile write port; writes to x0 are granted but suppressed here.
  always_ff @(posedge clock) begin
    if (!reset) begin
      regwrite <= 1'b0;
      wb_q     <= '0;
    end else begin
      regwrite <= any_gnt && (gnt_wb.rd != 5'd0);
      if (any_gnt) begin
        wb_q <= gnt_wb;
      end
    end
  end

  assign write_reg  = wb_q.rd;
  assign write_data = wb_q.data;
  assign busy_mask  = busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Latency: checks comb readies before the edge and the registered write 1 cycle after each grant.
// Backpressure: exercises priority, round-robin, starvation override and scoreboard stalls.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_ready;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        cp_valid;
  logic [4:0]  cp_rd;
  logic [31:0] cp_data;
  logic        cp_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        hazard;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] busy_mask;

  int total;
  int bad;

  regfile_wb_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .pipe_ready (pipe_ready),
    .mc_valid   (mc_valid),
    .mc_rd      (mc_rd),
    .mc_data    (mc_data),
    .mc_ready   (mc_ready),
    .cp_valid   (cp_valid),
    .cp_rd      (cp_rd),
    .cp_data    (cp_data),
    .cp_ready   (cp_ready),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_ready  (iss_ready),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .chk_rd     (chk_rd),
    .hazard     (hazard),
    .regwrite   (regwrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .busy_mask  (busy_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
    mc_valid = 0;   mc_rd = 0;   mc_data = 0;
    cp_valid = 0;   cp_rd = 0;   cp_data = 0;
    iss_valid = 0;  iss_rd = 0;
    chk_rs1 = 0;    chk_rs2 = 0; chk_rd = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 0;
    idle_inputs();
    tick();
    tick();

    // Reset state
    check("rst_pipe_ready", pipe_ready, 0);
    check("rst_mc_ready", mc_ready, 0);
    check("rst_cp_ready", cp_ready, 0);
    check("rst_iss_ready", iss_ready, 0);
    check("rst_regwrite", regwrite, 0);
    check("rst_write_reg", write_reg, 0);
    check("rst_write_data", write_data, 0);
    check("rst_busy", busy_mask, 0);
    reset = 1;
    #1;
    check("idle_pipe_ready", pipe_ready, 1);

    // Priority: pipe beats mc
    pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hA5A5A5A5;
    mc_valid = 1;   mc_rd = 3;   mc_data = 32'h11111111;
    #1;
    check("pri_pipe_ready", pipe_ready, 1);
    check("pri_mc_ready", mc_ready, 0);
    tick();
    idle_inputs();
    check("pri_regwrite", regwrite, 1);
    check("pri_write_reg", write_reg, 5);
    check("pri_write_data", write_data, 32'hA5A5A5A5);
    tick();
    check("idle_regwrite", regwrite, 0);

    // Round-robin between mc (rd 1) and cp (rd 2)
    mc_valid = 1; mc_rd = 1; mc_data = 32'h0000_0001;
    cp_valid = 1; cp_rd = 2; cp_data = 32'h0000_0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_mc_ready", mc_ready, (i % 2 == 0) ? 1 : 0);
      check("rr_cp_ready", cp_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      check("rr_regwrite", regwrite, 1);
      check("rr_write_reg", write_reg, (i % 2 == 0) ? 1 : 2);
      check("rr_write_data", write_data, (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    idle_inputs();

    // Starvation: pipe and mc held; pipe wins 4 cycles, then mc is forced
    pipe_valid = 1; pipe_rd = 9; pipe_data = 32'h0000_0099;
    mc_valid = 1;   mc_rd = 4;   mc_data = 32'h0000_0044;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stv_pipe_ready", pipe_ready, (c < 4) ? 1 : 0);
      check("stv_mc_ready", mc_ready, (c == 4) ? 1 : 0);
      tick();
      check("stv_write_reg", write_reg, (c < 4) ? 9 : 4);
    end
    #1;
    check("stv_cleared_pipe_ready", pipe_ready, 1);
    check("stv_cleared_mc_ready", mc_ready, 0);
    idle_inputs();
    tick();

    // Scoreboard
    iss_valid = 1; iss_rd = 7;
    #1;
    check("sb_iss_ready", iss_ready, 1);
    check("sb_hazard_before", hazard, 0);
    tick();
    check("sb_busy_set", busy_mask, 32'h80);
    chk_rs1 = 7;
    #1;
    check("sb_hazard_rs1", hazard, 1);
    check("sb_iss_stall", iss_ready, 0);
    chk_rs1 = 0; chk_rd = 7;
    #1;
    check("sb_hazard_rd", hazard, 1);
    chk_rd = 0; chk_rs2 = 6;
    #1;
    check("sb_hazard_other", hazard, 0);
    tick();
    check("sb_busy_held", busy_mask, 32'h80);
    iss_valid = 0; chk_rs2 = 0;
    mc_valid = 1; mc_rd = 7; mc_data = 32'h7777_7777;
    #1;
    check("sb_mc_ready", mc_ready, 1);
    tick();
    mc_valid = 0;
    check("sb_busy_clear", busy_mask, 0);
    check("sb_wb_data", write_data, 32'h7777_7777);
    // Same-cycle retire and reissue of rd 7
    iss_valid = 1; iss_rd = 7;
    tick();
    check("sb_busy_reset7", busy_mask, 32'h80);
    mc_valid = 1; mc_rd = 7;
    #1;
    check("sb_same_iss_ready", iss_ready, 0);
    check("sb_same_mc_ready", mc_ready, 1);
    tick();
    idle_inputs();
    check("sb_same_busy", busy_mask, 0);

    // x0 handling
    mc_valid = 1; mc_rd = 0; mc_data = 32'hFFFFFFFF;
    #1;
    check("x0_mc_ready", mc_ready, 1);
    tick();
    mc_valid = 0;
    check("x0_regwrite", regwrite, 0);
    iss_valid = 1; iss_rd = 0;
    #1;
    check("x0_iss_ready", iss_ready, 1);
    tick();
    check("x0_busy", busy_mask, 0);

    // Reset mid-operation (pointer currently favours cp after the mc grant above)
    iss_rd = 7;
    tick();
    iss_valid = 0;
    check("rmid_busy_pre", busy_mask, 32'h80);
    mc_valid = 1; mc_rd = 3; mc_data = 32'h3333_3333;
    reset = 0;
    #1;
    check("rmid_pipe_ready", pipe_ready, 0);
    check("rmid_mc_ready", mc_ready, 0);
    check("rmid_cp_ready", cp_ready, 0);
    check("rmid_iss_ready", iss_ready, 0);
    tick();
    check("rmid_busy", busy_mask, 0);
    check("rmid_regwrite", regwrite, 0);
    reset = 1;
    cp_valid = 1; cp_rd = 2; cp_data = 32'h2222_2222;
    #1;
    check("rmid_ptr_mc", mc_ready, 1);
    check("rmid_ptr_cp", cp_ready, 0);
    tick();
    idle_inputs();
    check("rmid_resume_regwrite", regwrite, 1);
    check("rmid_resume_reg", write_reg, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state on posedge; reset  in  1  synchronous, active-low reset.
REQ-002 SHALL have ports: pipe_valid in 1, pipe_rd in 5, pipe_data in 32, pipe_ready out 1; in-order pipeline writeback requester (R0).
REQ-003 SHALL have ports: mc_valid in 1, mc_rd in 5, mc_data in 32, mc_ready out 1; multicycle-unit writeback requester (R1).
REQ-004 SHALL have ports: cp_valid in 1, cp_rd in 5, cp_data in 32, cp_ready out 1; coprocessor writeback requester (R2).
REQ-005 SHALL have ports: iss_valid in 1, iss_rd in 5, iss_ready out 1; long-latency issue, marks rd busy.
REQ-006 SHALL have ports: chk_rs1 in 5, chk_rs2 in 5, chk_rd in 5, hazard out 1; decode-stage scoreboard query.
REQ-007 SHALL have ports: regwrite out 1, write_reg out 5, write_data out 32; drive the register file write port.
REQ-008 SHALL have port: busy_mask out 32; current scoreboard, bit n = xn pending.

Function
REQ-009 SHALL treat a requester as granted in a cycle when its valid and ready are both 1.
REQ-010 SHALL grant at most one of R0/R1/R2 per cycle; ready of non-granted requesters 0.
REQ-011 SHALL give R0 priority: pipe_ready=1 unless starvation override (REQ-013) is active.
REQ-012 SHALL arbitrate R1 vs R2 round-robin when R0 not granted; 1-bit pointer, reset to R1, moves to the other requester after each R1/R2 grant.
REQ-013 SHALL keep a 3-bit starvation counter, incremented each cycle R1 or R2 is valid but ungranted, cleared on any R1/R2 grant; at value 4 pipe_ready=0 and the RR winner among R1/R2 is granted.
REQ-014 SHALL register the granted rd/data: regwrite/write_reg/write_data valid exactly 1 cycle after grant (latency 1); regwrite=0 on cycles with no grant.
REQ-015 SHALL accept grants with rd=0 but drive regwrite=0 for them.
REQ-016 SHALL set busy[iss_rd] on issue handshake; iss_ready = !busy[iss_rd] (registered busy); iss with rd=0 accepted, sets nothing.
REQ-017 SHALL clear busy[rd] on an R1 or R2 grant; R0 grants never alter busy.
REQ-018 SHALL, on same-cycle clear of rd X and issue to X, reject the issue (iss_ready=0 from registered busy); busy[X] clears.
REQ-019 SHALL compute hazard combinationally = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd], index 0 contributing 0.
REQ-020 SHALL hold busy[0]=0 always.
REQ-021 SHALL allow R1/R2 writeback to a non-busy rd (no check); behaviour is a plain write.

Reset
REQ-022 SHALL, while reset=0 at posedge, clear busy to 0, counter to 0, RR pointer to R1, regwrite to 0, write_reg to 0, write_data to 0.
REQ-023 SHALL drive pipe_ready, mc_ready, cp_ready, iss_ready to 0 while reset=0; grants in flight are dropped, no write issued the following cycle.
REQ-024 SHALL resume normal arbitration the first cycle after reset returns to 1.

Verification
REQ-025 Priority: pipe_valid, mc_valid both 1, pipe_rd=5/data=0xA5A5A5A5 -> pipe_ready=1, mc_ready=0; next cycle regwrite=1, write_reg=5, write_data=0xA5A5A5A5.
REQ-026 Round-robin: pipe idle, mc_valid and cp_valid held 1 for 4 cycles -> grants R1,R2,R1,R2; write_reg sequence follows 1-cycle later.
REQ-027 Starvation: pipe_valid and mc_valid held 1 continuously -> pipe granted cycles 0-3, cycle 4 pipe_ready=0, mc_ready=1, counter cleared.
REQ-028 Scoreboard: issue rd=7 -> busy_mask=0x80, hazard=1 for chk_rs1=7; second issue rd=7 -> iss_ready=0; mc grant rd=7 -> busy_mask=0 next cycle.
REQ-029 x0: mc grant rd=0 data=0xFFFFFFFF -> mc_ready=1, next cycle regwrite=0; issue rd=0 -> busy_mask stays 0.
REQ-030 Reset mid-operation: busy_mask=0x80, mc grant pending, reset=0 one cycle -> busy_mask=0, regwrite=0, all readies 0, pointer at R1.
